rabbit_profile_loader: RTL

Upstream stage of the dual-DDS serializer. Receives byte-wide command frames from the Rabbit controller over an asynchronous strobed parallel bus and assembles 184-bit DDS profile words in a shadow buffer. Each completed word is committed atomically into a bank of profile slots, which drives the serializer's 184-bit profile inputs directly. The block also sets the sweep count consumed by the serializer.

---
 rtl/rabbit_profile_loader.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/rabbit_profile_loader.sv
// ============================================================================
// rabbit_profile_loader : assembles Rabbit byte frames into 184-bit DDS profile slots
// Optional: CHECKSUM_EN adds a trailing XOR byte to every LOAD frame.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rabbit_profile_loader #(
    parameter int NUM_PROFILES   = 12,
    parameter int PROFILE_BYTES  = 23,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                                  ten_MHz_ext_0,
    input  logic                                  key_2_reset_0,
    input  logic [7:0]                            rabbit_data,
    input  logic                                  rabbit_wr,
    input  logic                                  sweep_busy,
    output logic [NUM_PROFILES*PROFILE_BYTES*8-1:0] profile_bank,
    output logic [NUM_PROFILES-1:0]               slot_valid,
    output logic [4:0]                            sweep_total_0,
    output logic                                  load_done,
    output logic                                  frame_err,
    output logic                                  busy
);

    localparam int PW = PROFILE_BYTES * 8;
`ifdef CHECKSUM_EN
    localparam int FRAME_BYTES = PROFILE_BYTES + 1;
`else
    localparam int FRAME_BYTES = PROFILE_BYTES;
`endif
    localparam int CNT_W = $clog2(FRAME_BYTES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_LOAD        = 2'd1,
        S_DISCARD     = 2'd2,
        S_COMMIT_WAIT = 2'd3
    } state_t;

    state_t           r_state;
    logic [4:0]       r_slot;
    logic             r_clear;
    logic [PW-1:0]    r_shadow;
    logic [CNT_W-1:0] r_byte_cnt;
    logic [TO_W-1:0]  r_timeout;
    logic             r_wr_meta, r_wr_sync, r_wr_dly;
`ifdef CHECKSUM_EN
    logic [7:0]       r_xor;
`endif

    logic       w_strobe;
    logic [2:0] w_cmd;
    logic [4:0] w_arg;
    logic       w_last_byte;
    logic       w_timeout;

    assign w_strobe    = r_wr_sync & ~r_wr_dly;
    assign w_cmd       = rabbit_data[7:5];
    assign w_arg       = rabbit_data[4:0];
    assign w_last_byte = (r_byte_cnt == CNT_W'(FRAME_BYTES - 1));
    assign w_timeout   = (r_timeout == TO_W'(TIMEOUT_CYCLES));
    assign busy        = (r_state != S_IDLE);

    // The strobe is asynchronous; data is only sampled on the detect cycle.
    always_ff @(posedge ten_MHz_ext_0 or negedge key_2_reset_0) begin
        if (!key_2_reset_0) begin
            r_wr_meta <= 1'b0;
            r_wr_sync <= 1'b0;
            r_wr_dly  <= 1'b0;
        end else begin
            r_wr_meta <= rabbit_wr;
            r_wr_sync <= r_wr_meta;
            r_wr_dly  <= r_wr_sync;
        end
    end

    always_ff @(posedge ten_MHz_ext_0 or negedge key_2_reset_0) begin
        if (!key_2_reset_0) begin
            r_state       <= S_IDLE;
            r_slot        <= '0;
            r_clear       <= 1'b0;
            r_shadow      <= '0;
            r_byte_cnt    <= '0;
            r_timeout     <= '0;
            profile_bank  <= '0;
            slot_valid    <= '0;
            sweep_total_0 <= '0;
            load_done     <= 1'b0;
            frame_err     <= 1'b0;
`ifdef CHECKSUM_EN
            r_xor         <= '0;
`endif
        end else begin
            load_done <= 1'b0;
            frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_strobe) begin
                        case (w_cmd)
                            3'd1: begin
                                r_byte_cnt <= '0;
                                r_timeout  <= '0;
                                if (32'(w_arg) < NUM_PROFILES) begin
                                    r_slot   <= w_arg;
                                    r_clear  <= 1'b0;
                                    r_shadow <= '0;
`ifdef CHECKSUM_EN
                                    r_xor    <= '0;
`endif
                                    r_state  <= S_LOAD;
                                end else begin
                                    frame_err <= 1'b1;
                                    r_state   <= S_DISCARD;
                                end
                            end
                            3'd2: begin
                                sweep_total_0 <= w_arg;
                                load_done     <= 1'b1;
                            end
                            3'd3: begin
                                r_clear <= 1'b1;
                                r_state <= S_COMMIT_WAIT;
                            end
                            default: ;
                        endcase
                    end
                end

                S_LOAD: begin
                    if (w_strobe) begin
                        r_timeout  <= '0;
                        r_byte_cnt <= r_byte_cnt + CNT_W'(1);
`ifdef CHECKSUM_EN
                        if (w_last_byte) begin
                            if (rabbit_data == r_xor) begin
                                r_state <= S_COMMIT_WAIT;
                            end else begin
                                frame_err <= 1'b1;
                                r_shadow  <= '0;
                                r_state   <= S_IDLE;
                            end
                        end else begin
                            r_shadow <= {r_shadow[PW-9:0], rabbit_data};
                            r_xor    <= r_xor ^ rabbit_data;
                        end
`else
                        r_shadow <= {r_shadow[PW-9:0], rabbit_data};
                        if (w_last_byte) begin
                            r_state <= S_COMMIT_WAIT;
                        end
`endif
                    end else if (w_timeout) begin
                        frame_err <= 1'b1;
                        r_shadow  <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_timeout <= r_timeout + TO_W'(1);
                    end
                end

                S_DISCARD: begin
                    if (w_strobe) begin
                        r_timeout  <= '0;
                        r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                        if (w_last_byte) begin
                            r_state <= S_IDLE;
                        end
                    end else if (w_timeout) begin
                        frame_err <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_timeout <= r_timeout + TO_W'(1);
                    end
                end

                S_COMMIT_WAIT: begin
                    // A stray byte is dropped, but the pending commit still lands.
                    if (w_strobe) begin
                        frame_err <= 1'b1;
                    end
                    if (!sweep_busy) begin
                        if (r_clear) begin
                            profile_bank  <= '0;
                            slot_valid    <= '0;
                            sweep_total_0 <= '0;
                        end else begin
                            for (int k = 0; k < NUM_PROFILES; k++) begin
                                if (r_slot == 5'(k)) begin
                                    profile_bank[k*PW +: PW] <= r_shadow;
                                    slot_valid[k]            <= 1'b1;
                                end
                            end
                        end
                        load_done <= 1'b1;
                        r_clear   <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
